// File: rtl/traffic_phase_scheduler.sv
// Highway/country intersection phase sequencer: one shared down-counter times green, yellow
// and all-red phases; emergency requests steer the cycle back toward highway green.
module traffic_phase_scheduler #(
  parameter int TICK_DIV     = 1,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_c,
  input  logic [6:0] Timeout,
  input  logic [3:0] timeout,
  input  logic       emg_req,
  output logic [2:0] highway_light,
  output logic [2:0] country_light,
  output logic [2:0] phase,
  output logic       phase_start,
  output logic       emg_ack
);

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    ALL_RED_A   = 3'd2,
    CTRY_GREEN  = 3'd3,
    CTRY_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_e;

  localparam int             PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRES_LAST   = PW'(TICK_DIV - 1);
  localparam logic [6:0]     ALLRED_LOAD = 7'(ALLRED_TICKS - 1);

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [PW-1:0] pres_q, pres_d;
  logic [2:0]    hwy_q, hwy_d;
  logic [2:0]    ctry_q, ctry_d;
  logic          phase_start_q, phase_start_d;
  logic          emg_ack_q, emg_ack_d;
  logic          tick;
  logic          expired;
  logic [6:0]    green_load;
  logic [6:0]    yellow_load;

  // Lamp pattern {highway, country}; anything unrecognised shows all-red.
  function automatic logic [5:0] lamps(input state_e s);
    case (s)
      HWY_GREEN:   lamps = {3'b001, 3'b100};
      HWY_YELLOW:  lamps = {3'b010, 3'b100};
      CTRY_GREEN:  lamps = {3'b100, 3'b001};
      CTRY_YELLOW: lamps = {3'b100, 3'b010};
      default:     lamps = {3'b100, 3'b100};
    endcase
  endfunction

  always_comb begin
    tick        = (pres_q == PRES_LAST);
    pres_d      = tick ? '0 : pres_q + PW'(1);
    expired     = tick && (cnt_q == 7'd0);
    // A zero duration is served as one tick.
    green_load  = (Timeout == 7'd0) ? 7'd0 : Timeout - 7'd1;
    yellow_load = (timeout == 4'd0) ? 7'd0 : {3'b000, timeout - 4'd1};

    state_d = state_q;
    case (state_q)
      HWY_GREEN:   if (expired && sensor_c && !emg_req) state_d = HWY_YELLOW;
      HWY_YELLOW:  if (expired) state_d = ALL_RED_A;
      ALL_RED_A:   if (expired) state_d = emg_req ? ALL_RED_B : CTRY_GREEN;
      CTRY_GREEN:  if (tick && ((cnt_q == 7'd0) || !sensor_c || emg_req)) state_d = CTRY_YELLOW;
      CTRY_YELLOW: if (expired) state_d = ALL_RED_B;
      ALL_RED_B:   if (expired) state_d = HWY_GREEN;
      default:     state_d = ALL_RED_B;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        HWY_GREEN, CTRY_GREEN:   cnt_d = green_load;
        HWY_YELLOW, CTRY_YELLOW: cnt_d = yellow_load;
        default:                 cnt_d = ALLRED_LOAD;
      endcase
    end else if (tick && (cnt_q != 7'd0)) begin
      cnt_d = cnt_q - 7'd1;
    end

    // Registering the decode of the next state keeps lamps aligned with the phase code.
    {hwy_d, ctry_d} = lamps(state_d);
    phase_start_d   = (state_d != state_q);
    emg_ack_d       = emg_req && (state_d == HWY_GREEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HWY_GREEN;
      cnt_q         <= 7'd0;
      pres_q        <= '0;
      hwy_q         <= 3'b001;
      ctry_q        <= 3'b100;
      phase_start_q <= 1'b0;
      emg_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pres_q        <= pres_d;
      hwy_q         <= hwy_d;
      ctry_q        <= ctry_d;
      phase_start_q <= phase_start_d;
      emg_ack_q     <= emg_ack_d;
    end
  end

  assign highway_light = hwy_q;
  assign country_light = ctry_q;
  assign phase         = state_q;
  assign phase_start   = phase_start_q;
  assign emg_ack       = emg_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: a TICK_DIV=1 instance for phase timing and
// emergency behaviour, plus a TICK_DIV=4 instance sharing the same inputs for quantisation.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_c;
  logic       emg_req;
  logic [6:0] Timeout;
  logic [3:0] timeout;

  logic [2:0] hl, cl, ph;
  logic       ps, ea;
  logic [2:0] hl4, cl4, ph4;
  logic       ps4, ea4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(.TICK_DIV(1), .ALLRED_TICKS(1)) dut (
    .clk(clk), .reset(reset), .sensor_c(sensor_c), .Timeout(Timeout), .timeout(timeout),
    .emg_req(emg_req), .highway_light(hl), .country_light(cl), .phase(ph),
    .phase_start(ps), .emg_ack(ea)
  );

  traffic_phase_scheduler #(.TICK_DIV(4), .ALLRED_TICKS(1)) dut4 (
    .clk(clk), .reset(reset), .sensor_c(sensor_c), .Timeout(Timeout), .timeout(timeout),
    .emg_req(emg_req), .highway_light(hl4), .country_light(cl4), .phase(ph4),
    .phase_start(ps4), .emg_ack(ea4)
  );

  function automatic logic [2:0] exp_h(input int p);
    case (p)
      0:       exp_h = 3'b001;
      1:       exp_h = 3'b010;
      default: exp_h = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_c(input int p);
    case (p)
      3:       exp_c = 3'b001;
      4:       exp_c = 3'b010;
      default: exp_c = 3'b100;
    endcase
  endfunction

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset(input logic s);
    reset    = 1'b0;
    sensor_c = s;
    emg_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_phase(input logic [2:0] p, output logic ok);
    int n = 0;
    while (ph !== p && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (ph === p);
  endtask

  task automatic test_reset;
    reset = 1'b0; sensor_c = 1'b0; emg_req = 1'b0; Timeout = 7'd5; timeout = 4'd2;
    @(negedge clk);
    tests++;
    if (ph !== 3'd0 || hl !== 3'b001 || cl !== 3'b100 || ps !== 1'b0 || ea !== 1'b0) begin
      fails++;
      $display("FAIL reset: phase=%0d h=%b c=%b ps=%b ack=%b, want 0 001 100 0 0", ph, hl, cl, ps, ea);
    end
    tests++;
    if (ph4 !== 3'd0 || hl4 !== 3'b001 || cl4 !== 3'b100 || ps4 !== 1'b0 || ea4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_div4: phase=%0d h=%b c=%b ps=%b ack=%b, want 0 001 100 0 0", ph4, hl4, cl4, ps4, ea4);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_idle;
    int bad = 0;
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) begin
      tests++;
      if (ph !== 3'd0 || hl !== 3'b001 || cl !== 3'b100 || ps !== 1'b0) begin
        fails++; bad++;
        $display("FAIL idle cyc%0d: phase=%0d h=%b c=%b ps=%b, want 0 001 100 0", i, ph, hl, cl, ps);
      end
      @(negedge clk);
    end
    $display("[TB] idle 50 cycles, %0d bad", bad);
  endtask

  task automatic test_full_cycle;
    int exp_ph [18] = '{0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 0, 0, 0, 0, 0, 1};
    logic exp_ps;
    do_reset(1'b1);
    for (int i = 0; i < 18; i++) begin
      exp_ps = (i > 0) && (exp_ph[i] != exp_ph[i-1]);
      tests++;
      if (ph !== 3'(exp_ph[i]) || ps !== exp_ps || hl !== exp_h(exp_ph[i]) || cl !== exp_c(exp_ph[i])) begin
        fails++;
        $display("FAIL cycle cyc%0d: phase=%0d ps=%b h=%b c=%b, want %0d %b %b %b",
                 i, ph, ps, hl, cl, exp_ph[i], exp_ps, exp_h(exp_ph[i]), exp_c(exp_ph[i]));
      end
      tests++;
      if (hl[0] === 1'b1 && cl[0] === 1'b1) begin
        fails++;
        $display("FAIL both_green cyc%0d: h=%b c=%b, want never both green", i, hl, cl);
      end
      @(negedge clk);
    end
    $display("[TB] full cycle sequence checked");
  endtask

  task automatic test_sensor_drop;
    logic ok;
    do_reset(1'b1);
    wait_phase(3'd3, ok);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (!ok || ph !== 3'd3) begin
      fails++;
      $display("FAIL sensor_drop_green: phase=%0d reached=%b, want 3 1", ph, ok);
    end
    sensor_c = 1'b0;
    @(negedge clk);
    tests++;
    if (ph !== 3'd4 || ps !== 1'b1) begin
      fails++;
      $display("FAIL sensor_drop_yellow: phase=%0d ps=%b, want 4 1", ph, ps);
    end
    $display("[TB] sensor drop after 3 green cycles");
  endtask

  task automatic test_emergency;
    logic ok;
    int bad = 0;
    do_reset(1'b1);
    wait_phase(3'd3, ok);
    emg_req = 1'b1;
    @(negedge clk);
    tests++;
    if (!ok || ph !== 3'd4 || ps !== 1'b1 || ea !== 1'b0) begin
      fails++;
      $display("FAIL emg_yellow: phase=%0d ps=%b ack=%b reached=%b, want 4 1 0 1", ph, ps, ea, ok);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (ph !== 3'd5) begin
      fails++;
      $display("FAIL emg_allred: phase=%0d, want 5", ph);
    end
    @(negedge clk);
    tests++;
    if (ph !== 3'd0 || ea !== 1'b1 || hl !== 3'b001) begin
      fails++;
      $display("FAIL emg_hwy: phase=%0d ack=%b h=%b, want 0 1 001", ph, ea, hl);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (ph !== 3'd0 || ea !== 1'b1) begin
        fails++; bad++;
        $display("FAIL emg_hold cyc%0d: phase=%0d ack=%b, want 0 1", i, ph, ea);
      end
    end
    emg_req = 1'b0;
    @(negedge clk);
    tests++;
    if (ph !== 3'd1 || ea !== 1'b0) begin
      fails++;
      $display("FAIL emg_release: phase=%0d ack=%b, want 1 0", ph, ea);
    end
    $display("[TB] emergency preemption, %0d bad hold cycles", bad);
  endtask

  task automatic test_emg_allred;
    logic ok;
    do_reset(1'b1);
    wait_phase(3'd2, ok);
    emg_req = 1'b1;
    @(negedge clk);
    tests++;
    if (!ok || ph !== 3'd5) begin
      fails++;
      $display("FAIL emg_at_allred_a: phase=%0d reached=%b, want 5 1", ph, ok);
    end
    @(negedge clk);
    tests++;
    if (ph !== 3'd0 || ea !== 1'b1) begin
      fails++;
      $display("FAIL emg_allred_to_hwy: phase=%0d ack=%b, want 0 1", ph, ea);
    end
    emg_req = 1'b0;
    $display("[TB] emergency at ALL_RED_A diverts to ALL_RED_B");
  endtask

  task automatic test_async_reset;
    logic ok;
    do_reset(1'b1);
    wait_phase(3'd4, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL async_reach_yellow: phase=%0d, want 4", ph);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (ph !== 3'd0 || hl !== 3'b001 || cl !== 3'b100 || ps !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: phase=%0d h=%b c=%b ps=%b, want 0 001 100 0", ph, hl, cl, ps);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] async reset mid CTRY_YELLOW");
  endtask

  task automatic test_durations;
    logic ok;
    int n;
    Timeout = 7'd0;
    do_reset(1'b1);
    wait_phase(3'd3, ok);
    n = 0;
    while (ph === 3'd3 && n < 40) begin n++; @(negedge clk); end
    tests++;
    if (!ok || n != 1) begin
      fails++;
      $display("FAIL zero_green: green cycles=%0d, want 1", n);
    end
    Timeout = 7'd5;
    timeout = 4'd0;
    do_reset(1'b1);
    wait_phase(3'd1, ok);
    n = 0;
    while (ph === 3'd1 && n < 40) begin n++; @(negedge clk); end
    tests++;
    if (!ok || n != 1) begin
      fails++;
      $display("FAIL zero_yellow: yellow cycles=%0d, want 1", n);
    end
    timeout = 4'd2;
    do_reset(1'b1);
    wait_phase(3'd3, ok);
    Timeout = 7'd20;
    n = 0;
    while (ph === 3'd3 && n < 40) begin n++; @(negedge clk); end
    tests++;
    if (!ok || n != 5) begin
      fails++;
      $display("FAIL timeout_latch: green cycles=%0d, want 5", n);
    end
    Timeout = 7'd5;
    $display("[TB] zero durations and mid-phase Timeout change");
  endtask

  task automatic test_tick_div;
    int exp_len [6] = '{4, 8, 4, 20, 8, 4};
    int lens [6];
    logic [2:0] seqp [6];
    logic [2:0] cur;
    int run = 0;
    int k = 0;
    do_reset(1'b1);
    cur = ph4;
    for (int c = 0; c < 120 && k < 6; c++) begin
      run++;
      @(negedge clk);
      if (ph4 !== cur) begin
        lens[k] = run; seqp[k] = cur; k++;
        cur = ph4; run = 0;
      end
    end
    tests++;
    if (k != 6) begin
      fails++;
      $display("FAIL div4_bound: phases seen=%0d, want 6", k);
    end
    for (int i = 0; i < k; i++) begin
      tests++;
      if (seqp[i] !== 3'(i) || lens[i] != exp_len[i] || (lens[i] % 4) != 0) begin
        fails++;
        $display("FAIL div4_phase%0d: phase=%0d len=%0d, want %0d %0d", i, seqp[i], lens[i], i, exp_len[i]);
      end
    end
    $display("[TB] TICK_DIV=4 phase lengths checked (%0d phases)", k);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_cycle();
    test_sensor_drop();
    test_emergency();
    test_emg_allred();
    test_async_reset();
    test_durations();
    test_tick_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
